// File: rtl/spi_master_pkg.sv
// Shared types and defaults for the SPI master engine.
package spi_master_pkg;

    localparam int unsigned DefDataW = 8;
    localparam int unsigned DefDivW  = 8;
    localparam int unsigned DefNss   = 4;

    // Frame sequencing: select asserted through LEAD/SHIFT/TRAIL, released in GAP.
    typedef enum logic [2:0] {
        StIdle,
        StLead,
        StShift,
        StTrail,
        StGap
    } state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // True when an SCLK edge of the given kind is the MISO sample edge for this mode;
    // the opposite edge kind is the MOSI drive edge.
    function automatic logic samples_on(input spi_mode_t mode, input logic leading);
        return leading ^ mode.cpha;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period timer: down-counter that ticks when it reaches zero and reloads.
module spi_clk_div
    import spi_master_pkg::*;
#(
    parameter int unsigned DIV_W = DefDivW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == '0);

    // Restart on load, reload after each tick, otherwise count down.
    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (load || tick) begin
            cnt_d = div;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_engine.sv
// SPI master serialiser: frames parallel words onto the master SPI pins and returns the
// word sampled from MISO on a one-cycle rx_valid pulse.
module spi_master_engine
    import spi_master_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned DIV_W  = DefDivW,
    parameter int unsigned NSS    = DefNss,
    localparam int unsigned SS_W  = (NSS > 1) ? $clog2(NSS) : 1
) (
    input  logic              pclk,
    input  logic              n_p_reset,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cfg_cpol,
    input  logic              cfg_cpha,
    input  logic              cfg_lsb_first,
    input  logic [SS_W-1:0]   cfg_ss_sel,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              n_ss_en,
    output logic [NSS-1:0]    n_ss_out,
    output logic              n_sclk_en,
    output logic              sclk_out,
    output logic              n_mo_en,
    output logic              mo,
    input  logic              mi
);

    localparam int unsigned CNT_W = $clog2(2 * DATA_W);
    localparam int unsigned BIT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LastEdge = CNT_W'(2 * DATA_W - 1);

    state_t            state_q, state_d;
    spi_mode_t         mode_q;
    logic              lsb_q;
    logic [SS_W-1:0]   sel_q;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_load;
    logic [DATA_W-1:0] tx_word_q;
    logic [DATA_W-1:0] rx_sh_q;
    logic [DATA_W-1:0] rx_data_q;
    logic [CNT_W-1:0]  edge_q;
    logic              sclk_q;
    logic              mo_q;
    logic              rx_valid_q;

    logic              tick;
    logic              accept;
    logic              edge_tick;
    logic              leading;
    logic              do_sample;
    logic              do_drive;
    logic              frame_active;
    logic [BIT_W-1:0]  bit_idx;
    logic [BIT_W-1:0]  drive_idx;

    // Position in the word of the idx-th bit on the wire.
    function automatic logic [BIT_W-1:0] bit_pos(input logic [BIT_W-1:0] idx, input logic lsb);
        return lsb ? idx : BIT_W'(DATA_W - 1) - idx;
    endfunction

    function automatic logic frame_bit(input logic [DATA_W-1:0] word,
                                       input logic [BIT_W-1:0] idx, input logic lsb);
        return word[bit_pos(idx, lsb)];
    endfunction

    assign accept   = tx_valid && (state_q == StIdle);
    // The first half-period of a frame uses the divider being accepted, later ones the latch.
    assign div_load = accept ? cfg_div : div_q;

    spi_clk_div #(
        .DIV_W (DIV_W)
    ) u_clk_div (
        .clk   (pclk),
        .rst_n (n_p_reset),
        .load  (accept),
        .div   (div_load),
        .tick  (tick)
    );

    // Edge bookkeeping: even edges leave the idle level, odd edges return to it.
    assign edge_tick = (state_q == StShift) && tick;
    assign leading   = ~edge_q[0];
    assign bit_idx   = edge_q[CNT_W-1:1];
    assign do_sample = edge_tick && samples_on(mode_q, leading);
    // CPHA=0 presents the next bit on a trailing edge (none after the last edge);
    // CPHA=1 presents the current bit on its leading edge.
    assign do_drive  = edge_tick && !samples_on(mode_q, leading) && (edge_q != LastEdge);
    assign drive_idx = mode_q.cpha ? bit_idx : bit_idx + 1'b1;

    // Frame sequencing, advanced only on half-period ticks once a word is accepted.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StLead;
            StLead:  if (tick) state_d = StShift;
            StShift: if (tick && (edge_q == LastEdge)) state_d = StTrail;
            StTrail: if (tick) state_d = StGap;
            StGap:   if (tick) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge pclk or negedge n_p_reset) begin
        if (!n_p_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Per-frame snapshot of the word and configuration; later cfg changes wait for the next frame.
    always_ff @(posedge pclk or negedge n_p_reset) begin
        if (!n_p_reset) begin
            tx_word_q <= '0;
            mode_q    <= '0;
            lsb_q     <= 1'b0;
            sel_q     <= '0;
            div_q     <= '0;
        end else if (accept) begin
            tx_word_q <= tx_data;
            mode_q    <= '{cpol: cfg_cpol, cpha: cfg_cpha};
            lsb_q     <= cfg_lsb_first;
            sel_q     <= cfg_ss_sel;
            div_q     <= cfg_div;
        end
    end

    // SCLK, MOSI, edge counter and MISO capture.
    always_ff @(posedge pclk or negedge n_p_reset) begin
        if (!n_p_reset) begin
            sclk_q  <= 1'b0;
            mo_q    <= 1'b0;
            edge_q  <= '0;
            rx_sh_q <= '0;
        end else begin
            if (accept) begin
                sclk_q  <= cfg_cpol;
                mo_q    <= frame_bit(tx_data, '0, cfg_lsb_first);
                edge_q  <= '0;
                rx_sh_q <= '0;
            end else if (state_q == StIdle) begin
                sclk_q <= cfg_cpol;
            end else if (state_q == StTrail) begin
                sclk_q <= mode_q.cpol;
            end
            if (edge_tick) begin
                sclk_q <= ~sclk_q;
                edge_q <= edge_q + 1'b1;
            end
            if (do_sample) begin
                rx_sh_q[bit_pos(bit_idx, lsb_q)] <= mi;
            end
            if (do_drive) begin
                mo_q <= frame_bit(tx_word_q, drive_idx, lsb_q);
            end
        end
    end

    // Hand the received word back as the frame enters GAP.
    always_ff @(posedge pclk or negedge n_p_reset) begin
        if (!n_p_reset) begin
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            if ((state_q == StTrail) && tick) begin
                rx_valid_q <= 1'b1;
                rx_data_q  <= rx_sh_q;
            end
        end
    end

    assign frame_active = (state_q == StLead) || (state_q == StShift) || (state_q == StTrail);

    assign tx_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign n_ss_out  = frame_active ? ~(NSS'(1) << sel_q) : '1;
    assign n_ss_en   = ~frame_active;
    assign n_sclk_en = ~frame_active;
    assign n_mo_en   = ~frame_active;
    assign sclk_out  = sclk_q;
    assign mo        = mo_q;

endmodule

// File: tb/tb_spi_master_engine.sv
// Self-checking bench for spi_master_engine: an SPI slave model watches the pins each pclk
// and each finished frame is compared against expectations derived from the frame rules.
module tb_spi_master_engine;

    logic       pclk = 1'b0;
    logic       n_p_reset = 1'b0;
    logic [7:0] cfg_div = '0;
    logic       cfg_cpol = 1'b0;
    logic       cfg_cpha = 1'b0;
    logic       cfg_lsb_first = 1'b0;
    logic [1:0] cfg_ss_sel = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] tx_data = '0;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy;
    logic       n_ss_en;
    logic [3:0] n_ss_out;
    logic       n_sclk_en;
    logic       sclk_out;
    logic       n_mo_en;
    logic       mo;
    logic       mi;

    int checks = 0;
    int errors = 0;

    // Slave model configuration (what the bench expects the current frame to use).
    logic       m_cpol = 1'b0;
    logic       m_cpha = 1'b0;
    logic       m_lsb = 1'b0;
    logic [7:0] s_word = '0;
    logic       loopback = 1'b0;
    logic       slave_mi = 1'b0;

    assign mi = loopback ? mo : slave_mi;

    always #5 pclk = ~pclk;

    spi_master_engine dut (
        .pclk          (pclk),
        .n_p_reset     (n_p_reset),
        .cfg_div       (cfg_div),
        .cfg_cpol      (cfg_cpol),
        .cfg_cpha      (cfg_cpha),
        .cfg_lsb_first (cfg_lsb_first),
        .cfg_ss_sel    (cfg_ss_sel),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_data       (tx_data),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .busy          (busy),
        .n_ss_en       (n_ss_en),
        .n_ss_out      (n_ss_out),
        .n_sclk_en     (n_sclk_en),
        .sclk_out      (sclk_out),
        .n_mo_en       (n_mo_en),
        .mo            (mo),
        .mi            (mi)
    );

    function automatic int pos(input int j, input logic lsb);
        return lsb ? j : 7 - j;
    endfunction

    // Monitor / slave state (written only by the monitor).
    logic       prev_ss_low = 1'b0;
    logic       prev_sclk = 1'b0;
    logic       prev_mo = 1'b0;
    logic       ready_seen = 1'b0;
    logic [3:0] pat = 4'hF;
    logic [7:0] s_rx = '0;
    int ss_cnt = 0, edges = 0, lead_chg = 0, trail_chg = 0, mo_bad = 0;
    int first_lead = -1, second_lead = -1, t_idx = 0, r_idx = 0;
    int high_cnt = 0, rx_pulses = 0, frames_done = 0;
    // Snapshot of the last completed frame.
    int d_ss_cnt = 0, d_edges = 0, d_lead_chg = 0, d_trail_chg = 0, d_mo_bad = 0;
    int d_period = 0, d_gap = 0;
    logic [3:0] d_pat = 4'hF;
    logic [7:0] d_srx = '0;
    logic [7:0] d_rxw = '0;
    logic       d_ready = 1'b0;
    logic       d_rxv = 1'b0;

    // SPI slave model and frame statistics, sampled away from the active edge.
    always @(negedge pclk) begin : mon
        logic ss_low, edge_now, lead;
        ss_low   = (n_ss_out != 4'hF);
        edge_now = ss_low && prev_ss_low && (sclk_out != prev_sclk);
        lead     = (sclk_out != m_cpol);
        if (ss_low && !prev_ss_low) begin
            d_gap = high_cnt;
            ss_cnt = 0; edges = 0; lead_chg = 0; trail_chg = 0; mo_bad = 0;
            first_lead = -1; second_lead = -1; t_idx = 0; r_idx = 0;
            s_rx = '0; ready_seen = 1'b0; rx_pulses = 0;
            if (!m_cpha) slave_mi = s_word[pos(0, m_lsb)];
        end
        if (ss_low) begin
            ss_cnt++;
            pat = n_ss_out;
            if (tx_ready) ready_seen = 1'b1;
            if (prev_ss_low && (mo != prev_mo)) begin
                if (!edge_now) mo_bad++;
                else if (lead) lead_chg++;
                else trail_chg++;
            end
            if (edge_now) begin
                edges++;
                if (lead) begin
                    if (first_lead < 0) first_lead = ss_cnt;
                    else if (second_lead < 0) second_lead = ss_cnt;
                end
                if (lead != m_cpha) begin
                    if (r_idx < 8) s_rx[pos(r_idx, m_lsb)] = mo;
                    r_idx++;
                end else if (m_cpha) begin
                    if (t_idx < 8) slave_mi = s_word[pos(t_idx, m_lsb)];
                    t_idx++;
                end else begin
                    t_idx++;
                    if (t_idx < 8) slave_mi = s_word[pos(t_idx, m_lsb)];
                end
            end
        end else begin
            high_cnt++;
        end
        if (rx_valid) begin
            rx_pulses++;
            d_rxw = rx_data;
        end
        if (!ss_low && prev_ss_low) begin
            d_ss_cnt = ss_cnt; d_edges = edges; d_lead_chg = lead_chg; d_trail_chg = trail_chg;
            d_mo_bad = mo_bad; d_period = second_lead - first_lead; d_pat = pat;
            d_srx = s_rx; d_ready = ready_seen; d_rxv = rx_valid;
            high_cnt = 1;
            frames_done++;
        end
        prev_ss_low = ss_low;
        prev_sclk   = sclk_out;
        prev_mo     = mo;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic wait_frames(input int target);
        int budget;
        budget = 0;
        while ((frames_done < target) && (budget < 4000)) begin
            cycles(1);
            budget++;
        end
        chk("frame_done_in_time", 32'(frames_done >= target), 1);
    endtask

    task automatic set_cfg(input logic [7:0] s, input int div, input logic cpol, input logic cpha,
                           input logic lsb, input int sel);
        m_cpol = cpol; m_cpha = cpha; m_lsb = lsb; s_word = s;
        cfg_div = 8'(div); cfg_cpol = cpol; cfg_cpha = cpha; cfg_lsb_first = lsb;
        cfg_ss_sel = 2'(sel);
        cycles(3);
    endtask

    task automatic start_frame(input logic [7:0] tx, input logic [7:0] s, input int div,
                               input logic cpol, input logic cpha, input logic lsb, input int sel);
        set_cfg(s, div, cpol, cpha, lsb, sel);
        tx_data = tx;
        tx_valid = 1'b1;
        cycles(1);
        tx_valid = 1'b0;
    endtask

    // Expectations come from the framing rules: (2N+2) half-periods with select low,
    // 2N SCLK edges, MOSI moving only on the drive edge kind for the mode.
    task automatic check_frame(input string tag, input logic [7:0] tx, input logic [7:0] s,
                               input int div, input logic cpha, input logic lsb, input int sel);
        logic [3:0] pat_e;
        int h, trans;
        h = div + 1;
        pat_e = 4'hF;
        pat_e[sel] = 1'b0;
        trans = 0;
        for (int j = 1; j < 8; j++) begin
            if (tx[pos(j, lsb)] != tx[pos(j - 1, lsb)]) trans++;
        end
        chk({tag, "_ss_len"}, d_ss_cnt, 18 * h);
        chk({tag, "_ss_pat"}, 32'(d_pat), 32'(pat_e));
        chk({tag, "_edges"}, d_edges, 16);
        chk({tag, "_sclk_period"}, d_period, 2 * h);
        chk({tag, "_mo_lead_chg"}, d_lead_chg, cpha ? trans : 0);
        chk({tag, "_mo_trail_chg"}, d_trail_chg, cpha ? 0 : trans);
        chk({tag, "_mo_off_edge"}, d_mo_bad, 0);
        chk({tag, "_slave_rx"}, 32'(d_srx), 32'(tx));
        chk({tag, "_rx_valid_gap"}, 32'(d_rxv), 1);
        chk({tag, "_rx_data"}, 32'(d_rxw), loopback ? 32'(tx) : 32'(s));
        chk({tag, "_ready_in_frame"}, 32'(d_ready), 0);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] tx, input logic [7:0] s,
                             input int div, input logic cpol, input logic cpha, input logic lsb,
                             input int sel);
        int n0;
        n0 = frames_done;
        start_frame(tx, s, div, cpol, cpha, lsb, sel);
        wait_frames(n0 + 1);
        cycles(6);
        check_frame(tag, tx, s, div, cpha, lsb, sel);
        chk({tag, "_rx_pulses"}, rx_pulses, 1);
        chk({tag, "_idle_sclk"}, 32'(sclk_out), 32'(cpol));
        chk({tag, "_idle_busy"}, 32'(busy), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_n_ss_out"}, 32'(n_ss_out), 32'hF);
        chk({tag, "_enables"}, {29'd0, n_ss_en, n_sclk_en, n_mo_en}, 32'h7);
        chk({tag, "_sclk_mo"}, {30'd0, sclk_out, mo}, 0);
        chk({tag, "_ready_busy"}, {30'd0, tx_ready, busy}, 32'h2);
        chk({tag, "_rx_valid"}, 32'(rx_valid), 0);
        chk({tag, "_rx_data"}, 32'(rx_data), 0);
    endtask

    initial begin : stim
        logic [7:0] w0, w1, r;
        int n0, budget, dv, sl;
        logic cp, ch, lb;

        // Reset values, with cfg_cpol high to show reset wins over idle-follow.
        cfg_cpol = 1'b1;
        cycles(3);
        check_reset_outputs("reset");
        n_p_reset = 1'b1;
        cycles(2);
        chk("idle_follows_cpol", 32'(sclk_out), 1);

        // Mode 0, div 0, MSB first, sel 0, MISO looped from MOSI.
        loopback = 1'b1;
        run_frame("mode0", 8'hA5, 8'h00, 0, 1'b0, 1'b0, 1'b0, 0);
        loopback = 1'b0;

        // Mode 3, div 3, LSB first, slave returns 8'h3C.
        run_frame("mode3", 8'h5A, 8'h3C, 3, 1'b1, 1'b1, 1'b1, 1);

        // Mode 1 vs mode 2 with 8'h81: MOSI moves on leading vs trailing edges only.
        run_frame("mode1", 8'h81, 8'h96, 0, 1'b0, 1'b1, 1'b0, 3);
        run_frame("mode2", 8'h81, 8'h69, 0, 1'b1, 1'b0, 1'b0, 3);

        // Back-to-back: tx_valid held across two words, div 1.
        set_cfg(8'hC3, 1, 1'b0, 1'b0, 1'b0, 0);
        w0 = 8'h3E;
        w1 = 8'hD1;
        n0 = frames_done;
        tx_data = w0;
        tx_valid = 1'b1;
        budget = 0;
        while (!busy && budget < 20) begin cycles(1); budget++; end
        chk("b2b_accept0_ready", 32'(tx_ready), 0);
        tx_data = w1;
        wait_frames(n0 + 1);
        check_frame("b2b0", w0, 8'hC3, 1, 1'b0, 1'b0, 0);
        budget = 0;
        while ((n_ss_out == 4'hF) && budget < 50) begin cycles(1); budget++; end
        tx_valid = 1'b0;
        chk("b2b_second_started", 32'(n_ss_out != 4'hF), 1);
        wait_frames(n0 + 2);
        cycles(4);
        check_frame("b2b1", w1, 8'hC3, 1, 1'b0, 1'b0, 0);
        chk("b2b_ss_gap", d_gap, 1 + 2);
        chk("b2b_no_third", 32'(busy), 0);

        // cfg_div / cfg_ss_sel changed mid-frame: current frame keeps div 1, sel 0.
        n0 = frames_done;
        start_frame(8'h4B, 8'hB4, 1, 1'b0, 1'b0, 1'b0, 0);
        cycles(5);
        cfg_div = 8'd3;
        cfg_ss_sel = 2'd2;
        wait_frames(n0 + 1);
        cycles(6);
        check_frame("midcfg", 8'h4B, 8'hB4, 1, 1'b0, 1'b0, 0);
        run_frame("newcfg", 8'h27, 8'hE8, 3, 1'b0, 1'b0, 1'b0, 2);

        // Reset asserted mid-SHIFT aborts the frame.
        start_frame(8'hF0, 8'h0F, 3, 1'b1, 1'b1, 1'b1, 1);
        cycles(25);
        chk("abort_busy_before", 32'(busy), 1);
        n_p_reset = 1'b0;
        #1;
        check_reset_outputs("abort");
        cycles(3);
        n_p_reset = 1'b1;
        cycles(40);
        chk("abort_no_rx_valid", rx_pulses, 0);
        chk("abort_idle_sclk", 32'(sclk_out), 1);
        run_frame("after_abort", 8'h9C, 8'h63, 1, 1'b1, 1'b1, 1'b1, 1);

        // Randomized frames.
        for (int k = 0; k < 6; k++) begin
            w0 = 8'($urandom);
            r  = 8'($urandom);
            dv = int'($urandom_range(0, 3));
            sl = int'($urandom_range(0, 3));
            cp = 1'($urandom);
            ch = 1'($urandom);
            lb = 1'($urandom);
            run_frame($sformatf("rand%0d", k), w0, r, dv, cp, ch, lb, sl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
